// File: rtl/mdu_pkg.sv
// Shared types for the M-extension issue controller: opcodes, FSM states and
// the operand key used by the single-entry result cache.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN,
        S_WB
    } mdu_state_e;

    localparam int DEFAULT_TIMEOUT = 48;
    localparam int DEFAULT_CNT_W   = 6;

    typedef struct packed {
        mul_op_e     opcode;
        logic [31:0] op1;
        logic [31:0] op2;
    } mul_key_t;

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// EX-stage side of the multiply issue controller: request, stall/ready,
// writeback and the in-flight destination tag for hazard detection.
interface mdu_issue_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_opcode;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  busy_rd;

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, req_rd,
        input  req_ready, stall, wb_valid, wb_rd, wb_data, busy_rd
    );

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, req_rd,
        output req_ready, stall, wb_valid, wb_rd, wb_data, busy_rd
    );
endinterface

// File: rtl/mdu_result_cache.sv
// Single-entry memo of the last completed multiply: {opcode, op1, op2} -> result.
// A write takes priority over an invalidate in the same cycle.
module mdu_result_cache
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  mul_key_t    lookup_key,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        wr_en,
    input  mul_key_t    wr_key,
    input  logic [31:0] wr_data,
    input  logic        inv
);

    logic        valid;
    mul_key_t    key;
    logic [31:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            key   <= '0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            key   <= wr_key;
            data  <= wr_data;
        end else if (inv) begin
            valid <= 1'b0;
        end
    end

    assign hit      = valid && (key == lookup_key);
    assign hit_data = data;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller between EX and the iterative multiplier: launches
// ops, stalls EX until the result returns, handles flush, watchdog and result reuse.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    mdu_issue_ctrl_if.slave ex,
    input  logic            flush,
    output logic            mul_start,
    output logic [1:0]      mul_opcode,
    output logic [31:0]     mul_op1,
    output logic [31:0]     mul_op2,
    input  logic [31:0]     mul_result,
    input  logic            mul_done,
    output logic            timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mdu_state_e  state;
    mul_op_e     lat_opcode;
    logic [31:0] lat_op1;
    logic [31:0] lat_op2;
    logic [4:0]  lat_rd;
    logic [CNT_W-1:0] cnt;
    logic        wb_vld_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    mul_key_t    req_key;
    mul_key_t    lat_key;
    logic        hit;
    logic [31:0] hit_data;
    logic        req_take;
    logic        cnt_last;
    logic        cache_wr;
    logic        cache_inv;

    assign req_key  = '{opcode: mul_op_e'(ex.req_opcode), op1: ex.req_op1, op2: ex.req_op2};
    assign lat_key  = '{opcode: lat_opcode, op1: lat_op1, op2: lat_op2};
    assign req_take = ex.req_valid && !flush;
    assign cnt_last = (cnt == CNT_LAST);

    // The cache learns every result that lands in WAIT, even when a flush
    // kills the writeback in that same cycle.
    assign cache_wr  = (state == S_WAIT) && mul_done;
    assign cache_inv = (state == S_WAIT) && !mul_done && !flush && cnt_last;

    mdu_result_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .lookup_key (req_key),
        .hit        (hit),
        .hit_data   (hit_data),
        .wr_en      (cache_wr),
        .wr_key     (lat_key),
        .wr_data    (mul_result),
        .inv        (cache_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_opcode  <= OP_MUL;
            lat_op1     <= '0;
            lat_op2     <= '0;
            lat_rd      <= '0;
            cnt         <= '0;
            mul_start   <= 1'b0;
            wb_vld_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            wb_vld_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_take) begin
                        lat_rd <= ex.req_rd;
                        if (hit) begin
                            state    <= S_WB;
                            wb_vld_q <= (ex.req_rd != 5'd0);
                            if (ex.req_rd != 5'd0) begin
                                wb_rd_q   <= ex.req_rd;
                                wb_data_q <= hit_data;
                            end
                        end else begin
                            lat_opcode <= mul_op_e'(ex.req_opcode);
                            lat_op1    <= ex.req_op1;
                            lat_op2    <= ex.req_op2;
                            mul_start  <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_WB;
                            wb_vld_q <= (lat_rd != 5'd0);
                            if (lat_rd != 5'd0) begin
                                wb_rd_q   <= lat_rd;
                                wb_data_q <= mul_result;
                            end
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end else if (cnt_last) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        state <= S_IDLE;
                    end else if (cnt_last) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_opcode = lat_opcode;
    assign mul_op1    = lat_op1;
    assign mul_op2    = lat_op2;

    // Handshake outputs are forced low while reset is held so EX sees a quiet
    // controller even if it keeps presenting a request.
    assign ex.req_ready = !rst && (state == S_IDLE);
    assign ex.stall     = !rst && (((state == S_IDLE) && req_take) ||
                                   (state == S_LAUNCH) || (state == S_WAIT) ||
                                   ((state == S_DRAIN) && ex.req_valid));
    assign ex.busy_rd   = ((state == S_LAUNCH) || (state == S_WAIT) || (state == S_WB)) ?
                          {1'b1, lat_rd} : 6'd0;

    // A flush arriving in the WB cycle still kills the retiring op.
    assign ex.wb_valid  = wb_vld_q && !flush;
    assign ex.wb_rd     = wb_rd_q;
    assign ex.wb_data   = wb_data_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural iterative-multiplier model.
module tb_mdu_issue_ctrl;

    localparam int MUL_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        timeout_err;
    bit          hang = 1'b0;
    int          mc;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl_if ex_if ();

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(48), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex          (ex_if),
        .flush       (flush),
        .mul_start   (mul_start),
        .mul_opcode  (mul_opcode),
        .mul_op1     (mul_op1),
        .mul_op2     (mul_op2),
        .mul_result  (mul_result),
        .mul_done    (mul_done),
        .timeout_err (timeout_err)
    );

    function automatic logic [31:0] calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'b00:   p = {32'd0, a} * {32'd0, b};
            2'b01:   p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            2'b10:   p = 64'($signed({{32{a[31]}}, a}) * $signed({32'd0, b}));
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model: done pulses MUL_LAT+1 cycles after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc         <= 0;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start && !hang) begin
                mc         <= MUL_LAT;
                mul_result <= calc(mul_opcode, mul_op1, mul_op2);
            end else if (mc > 0) begin
                mc <= mc - 1;
                if (mc == 1) mul_done <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_if.req_valid  = 1'b1;
        ex_if.req_opcode = o;
        ex_if.req_op1    = a;
        ex_if.req_op2    = b;
        ex_if.req_rd     = rd;
    endtask

    // Presents one op and observes until the controller is back in IDLE (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          output int starts, output int sc, output int dc, output int wc, output int nwb,
                          output int ic, output logic [4:0] wr, output logic [31:0] wd,
                          output logic ws, output logic [5:0] br1);
        present(o, a, b, rd);
        starts = 0; sc = -1; dc = -1; wc = -1; nwb = 0; ic = -1;
        wr = '0; wd = '0; ws = 1'b1; br1 = '0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (c == 1) br1 = ex_if.busy_rd;
            if (mul_start) begin starts++; sc = c; end
            if (mul_done) dc = c;
            if (ex_if.wb_valid) begin
                nwb++; wc = c; wr = ex_if.wb_rd; wd = ex_if.wb_data; ws = ex_if.stall;
            end
            if (ex_if.req_ready) begin ic = c; break; end
        end
        ex_if.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        n_cmp++;
        if ({ex_if.stall, ex_if.req_ready, mul_start, ex_if.wb_valid, timeout_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_ctrl: got %b want 00000", {ex_if.stall, ex_if.req_ready, mul_start, ex_if.wb_valid, timeout_err});
        end
        n_cmp++;
        if ({ex_if.busy_rd, ex_if.wb_rd, ex_if.wb_data, mul_op1, mul_opcode} !== '0) begin
            n_bad++;
            $display("FAIL rst_data: busy_rd=%h wb_rd=%h wb_data=%h op1=%h want all 0",
                     ex_if.busy_rd, ex_if.wb_rd, ex_if.wb_data, mul_op1);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ex_if.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready_after: got %b want 1", ex_if.req_ready);
        end
    endtask

    task automatic test_mul_basic();
        int starts, sc, dc, wc, nwb, ic;
        logic [4:0] wr; logic [31:0] wd; logic ws; logic [5:0] br1;
        present(2'b00, 32'd7, 32'd6, 5'd5);
        #1;
        n_cmp++;
        if (ex_if.stall !== 1'b1) begin n_bad++; $display("FAIL t1_accept_stall: got %b want 1", ex_if.stall); end
        run_op(2'b00, 32'd7, 32'd6, 5'd5, starts, sc, dc, wc, nwb, ic, wr, wd, ws, br1);
        n_cmp++;
        if (starts !== 1 || sc !== 1) begin n_bad++; $display("FAIL t1_start: got %0d pulses at %0d want 1 at 1", starts, sc); end
        n_cmp++;
        if (br1 !== 6'h25) begin n_bad++; $display("FAIL t1_busy_rd: got %h want 25", br1); end
        n_cmp++;
        if (dc < 0 || wc !== dc + 1 || nwb !== 1) begin
            n_bad++; $display("FAIL t1_wb_timing: done=%0d wb=%0d nwb=%0d want wb=done+1, 1 wb", dc, wc, nwb);
        end
        n_cmp++;
        if (wr !== 5'd5 || wd !== 32'd42) begin n_bad++; $display("FAIL t1_wb_value: rd=%0d data=%0d want 5 42", wr, wd); end
        n_cmp++;
        if (ws !== 1'b0) begin n_bad++; $display("FAIL t1_wb_stall: got %b want 0", ws); end
    endtask

    task automatic test_cache_hit();
        present(2'b00, 32'd7, 32'd6, 5'd9);
        tick();
        n_cmp++;
        if (ex_if.wb_valid !== 1'b1 || ex_if.wb_data !== 32'd42 || ex_if.wb_rd !== 5'd9) begin
            n_bad++; $display("FAIL t2_hit_wb: v=%b data=%0d rd=%0d want 1 42 9", ex_if.wb_valid, ex_if.wb_data, ex_if.wb_rd);
        end
        n_cmp++;
        if (mul_start !== 1'b0 || ex_if.stall !== 1'b0 || ex_if.busy_rd !== 6'h29) begin
            n_bad++; $display("FAIL t2_hit_ctrl: start=%b stall=%b busy=%h want 0 0 29", mul_start, ex_if.stall, ex_if.busy_rd);
        end
        tick();
        ex_if.req_valid = 1'b0;
        n_cmp++;
        if (ex_if.req_ready !== 1'b1 || mul_start !== 1'b0) begin
            n_bad++; $display("FAIL t2_back_idle: ready=%b start=%b want 1 0", ex_if.req_ready, mul_start);
        end
    endtask

    task automatic test_flush_drain();
        int starts = 0, dc = -1, wc = -1, nwb = 0, drain_bad = 0;
        logic [4:0] wr = '0; logic [31:0] wd = '0;
        tick();
        present(2'b01, 32'h8000_0000, 32'd2, 5'd7);
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (mul_start) starts++;
            if (mul_done && dc < 0) dc = c;
            if (ex_if.wb_valid) begin nwb++; wc = c; wr = ex_if.wb_rd; wd = ex_if.wb_data; end
            if (c >= 12 && (dc < 0 || c == dc)) begin
                if (ex_if.stall !== 1'b1 || ex_if.req_ready !== 1'b0 || ex_if.busy_rd !== 6'd0) drain_bad++;
            end
            if (c == 11) flush = 1'b1;
            if (c == 12) begin flush = 1'b0; present(2'b00, 32'd7, 32'd6, 5'd4); end
            if (wc > 0 && ex_if.req_ready) break;
        end
        flush = 1'b0;
        ex_if.req_valid = 1'b0;
        n_cmp++;
        if (starts !== 1) begin n_bad++; $display("FAIL t3_starts: got %0d want 1", starts); end
        n_cmp++;
        if (drain_bad !== 0) begin n_bad++; $display("FAIL t3_drain_stall: %0d bad DRAIN cycles want 0", drain_bad); end
        n_cmp++;
        if (dc < 0 || wc !== dc + 2 || nwb !== 1) begin
            n_bad++; $display("FAIL t3_accept_after_done: done=%0d wb=%0d nwb=%0d want wb=done+2, 1 wb", dc, wc, nwb);
        end
        n_cmp++;
        if (wr !== 5'd4 || wd !== 32'd42) begin n_bad++; $display("FAIL t3_cache_kept: rd=%0d data=%0d want 4 42", wr, wd); end
    endtask

    task automatic test_rd_zero();
        int starts, sc, dc, wc, nwb, ic;
        logic [4:0] wr; logic [31:0] wd; logic ws; logic [5:0] br1;
        tick();
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, starts, sc, dc, wc, nwb, ic, wr, wd, ws, br1);
        n_cmp++;
        if (nwb !== 0 || starts !== 1 || ic < 0) begin
            n_bad++; $display("FAIL t4_rd0: wb=%0d starts=%0d idle=%0d want 0 1 >=0", nwb, starts, ic);
        end
        n_cmp++;
        if (ex_if.wb_rd !== 5'd4 || ex_if.wb_data !== 32'd42) begin
            n_bad++; $display("FAIL t4_wb_hold: rd=%0d data=%h want 4 0000002a", ex_if.wb_rd, ex_if.wb_data);
        end
        present(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        tick();
        n_cmp++;
        if (ex_if.wb_valid !== 1'b1 || ex_if.wb_data !== 32'hFFFF_FFFE || ex_if.wb_rd !== 5'd3 || mul_start !== 1'b0) begin
            n_bad++; $display("FAIL t4_hit: v=%b data=%h rd=%0d start=%b want 1 fffffffe 3 0",
                              ex_if.wb_valid, ex_if.wb_data, ex_if.wb_rd, mul_start);
        end
        tick();
        ex_if.req_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int starts, sc, dc, wc, nwb, ic;
        logic [4:0] wr; logic [31:0] wd; logic ws; logic [5:0] br1;
        hang = 1'b1;
        tick();
        run_op(2'b00, 32'd3, 32'd5, 5'd6, starts, sc, dc, wc, nwb, ic, wr, wd, ws, br1);
        hang = 1'b0;
        n_cmp++;
        if (ic !== 50 || timeout_err !== 1'b1 || nwb !== 0) begin
            n_bad++; $display("FAIL t5_timeout: idle at %0d err=%b wb=%0d want 50 1 0", ic, timeout_err, nwb);
        end
        tick();
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, starts, sc, dc, wc, nwb, ic, wr, wd, ws, br1);
        n_cmp++;
        if (starts !== 1 || nwb !== 1 || wd !== 32'hFFFF_FFFE || wr !== 5'd3) begin
            n_bad++; $display("FAIL t5_cache_invalid: starts=%0d wb=%0d data=%h rd=%0d want 1 1 fffffffe 3", starts, nwb, wd, wr);
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL t5_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int starts, sc, dc, wc, nwb, ic;
        logic [4:0] wr; logic [31:0] wd; logic ws; logic [5:0] br1;
        tick();
        present(2'b00, 32'd9, 32'd9, 5'd8);
        for (int c = 1; c <= 5; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ex_if.stall, ex_if.wb_valid, timeout_err, mul_start, ex_if.req_ready} !== 5'b0 || ex_if.busy_rd !== 6'd0) begin
            n_bad++; $display("FAIL t6_async_rst: stall=%b wb=%b err=%b start=%b ready=%b busy=%h want all 0",
                              ex_if.stall, ex_if.wb_valid, timeout_err, mul_start, ex_if.req_ready, ex_if.busy_rd);
        end
        ex_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(2'b00, 32'd9, 32'd9, 5'd8, starts, sc, dc, wc, nwb, ic, wr, wd, ws, br1);
        n_cmp++;
        if (starts !== 1 || nwb !== 1 || wd !== 32'd81 || wr !== 5'd8 || wc !== dc + 1) begin
            n_bad++; $display("FAIL t6_fresh_op: starts=%0d wb=%0d data=%0d rd=%0d done=%0d wbc=%0d want 1 1 81 8 wb=done+1",
                              starts, nwb, wd, wr, dc, wc);
        end
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL t6_err_cleared: got %b want 0", timeout_err); end
    endtask

    initial begin
        ex_if.req_valid  = 1'b0;
        ex_if.req_opcode = 2'b00;
        ex_if.req_op1    = '0;
        ex_if.req_op2    = '0;
        ex_if.req_rd     = '0;
        test_reset();
        test_mul_basic();
        test_cache_hit();
        test_flush_drain();
        test_rd_zero();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
